x_host: RTL and testbench

X_HOST -- requirements
Module: x_host

---
 rtl/x_host_if.sv | 31 +++
 rtl/x_host.sv | 159 +++++++++++++++
 tb/tb_x_host.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x_host_if.sv
// Bus bundle between x_host and its command source, delay-line driver and response sink.
// The master modport is the x_host side; the slave modport is the environment side.
interface x_host_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [1:0]  i_cmd_op;
    logic [31:0] i_cmd_wdata;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic [7:0]  o_tx_data;
    logic        i_rx_valid;
    logic        o_rx_accept;
    logic [7:0]  i_rx_data;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;
    logic        o_busy;

    modport master (
        input  i_cmd_valid, i_cmd_op, i_cmd_wdata, i_tx_ready, i_rx_valid, i_rx_data, i_rsp_ready,
        output o_cmd_ready, o_tx_valid, o_tx_data, o_rx_accept, o_rsp_valid, o_rsp_data, o_rsp_err,
               o_busy
    );

    modport slave (
        output i_cmd_valid, i_cmd_op, i_cmd_wdata, i_tx_ready, i_rx_valid, i_rx_data, i_rsp_ready,
        input  o_cmd_ready, o_tx_valid, o_tx_data, o_rx_accept, o_rsp_valid, o_rsp_data, o_rsp_err,
               o_busy
    );
endinterface

// File: rtl/x_host.sv
// Delay-line host: turns WRITE/READ/MEASURE commands into load/start/unload byte sequences
// for the driver and assembles the 32-bit response from returned bytes.
module x_host #(
    parameter int SETTLE     = 4,
    parameter int RX_TIMEOUT = 255
) (
    input  logic     i_clk,
    input  logic     i_rst,
    x_host_if.master bus
);
    typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_MEASURE, OP_RSVD} op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_SETTLE, S_UNLOAD, S_WAIT_RX, S_RSP
    } state_t;

    localparam int TO_W = (RX_TIMEOUT < 2) ? 1 : $clog2(RX_TIMEOUT);
    localparam int ST_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RX_TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE - 1);

    localparam logic [7:0] BYTE_UNLOAD = 8'h01;
    localparam logic [7:0] BYTE_START  = 8'h02;

    state_t          state_q, state_d;
    logic [31:0]     wdata_q;
    logic [2:0]      load_cnt;
    logic [1:0]      rd_cnt;
    logic [ST_W-1:0] settle_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [31:0]     rsp_data_q;
    logic            rsp_err_q;

    logic       cmd_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       cmd_hs;
    logic       tx_hs;

    assign cmd_hs = bus.i_cmd_valid & cmd_ready;
    assign tx_hs  = tx_valid & bus.i_tx_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    unique case (op_t'(bus.i_cmd_op))
                        OP_WRITE:   state_d = S_LOAD;
                        OP_READ:    state_d = S_UNLOAD;
                        OP_MEASURE: state_d = S_START;
                        OP_RSVD:    state_d = S_RSP;
                    endcase
                end
            end
            S_LOAD:    if (tx_hs && load_cnt == 3'd7) state_d = S_RSP;
            S_START:   if (tx_hs) state_d = (SETTLE == 0) ? S_UNLOAD : S_SETTLE;
            S_SETTLE:  if (settle_cnt == ST_LAST) state_d = S_UNLOAD;
            S_UNLOAD:  if (tx_hs) state_d = S_WAIT_RX;
            S_WAIT_RX: begin
                // A byte arriving on the last timeout cycle wins over the timeout.
                if (bus.i_rx_valid) begin
                    state_d = (rd_cnt == 2'd3) ? S_RSP : S_UNLOAD;
                end else if (to_cnt == TO_LAST) begin
                    state_d = S_RSP;
                end
            end
            S_RSP:     if (bus.i_rsp_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        unique case (state_q)
            S_IDLE:   cmd_ready = 1'b1;
            S_LOAD: begin
                tx_valid = 1'b1;
                tx_data  = {wdata_q[31:28], 4'h0};
            end
            S_START: begin
                tx_valid = 1'b1;
                tx_data  = BYTE_START;
            end
            S_UNLOAD: begin
                tx_valid = 1'b1;
                tx_data  = BYTE_UNLOAD;
            end
            default: ;
        endcase
    end

    // Datapath: wdata shifts left one nibble per load byte so the next nibble is always on top.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wdata_q    <= '0;
            load_cnt   <= '0;
            rd_cnt     <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_hs) begin
                        wdata_q    <= bus.i_cmd_wdata;
                        load_cnt   <= '0;
                        rd_cnt     <= '0;
                        rsp_data_q <= '0;
                        rsp_err_q  <= (op_t'(bus.i_cmd_op) == OP_RSVD);
                    end
                end
                S_LOAD: begin
                    if (tx_hs) begin
                        wdata_q  <= {wdata_q[27:0], 4'h0};
                        load_cnt <= load_cnt + 3'd1;
                    end
                end
                S_START:  settle_cnt <= '0;
                S_SETTLE: settle_cnt <= settle_cnt + 1'b1;
                S_UNLOAD: to_cnt <= '0;
                S_WAIT_RX: begin
                    if (bus.i_rx_valid) begin
                        rsp_data_q <= {rsp_data_q[23:0], bus.i_rx_data};
                        rd_cnt     <= rd_cnt + 2'd1;
                    end else if (to_cnt == TO_LAST) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_cmd_ready = cmd_ready;
    assign bus.o_tx_valid  = tx_valid;
    assign bus.o_tx_data   = tx_data;
    assign bus.o_rx_accept = bus.i_rx_valid;
    assign bus.o_rsp_valid = (state_q == S_RSP);
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_x_host.sv
// Scoreboard bench for x_host: a driver model answers unload bytes, expected tx bytes and
// responses are queued per command and popped as the DUT produces them.
module tb_x_host;
    localparam int SETTLE = 4;
    localparam int RX_TO  = 40;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    x_host_if bus ();

    x_host #(.SETTLE(SETTLE), .RX_TIMEOUT(RX_TO)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.master)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] tx_exp[$];
    rsp_t       rsp_exp[$];
    logic [7:0] rx_src[$];
    int         rx_lat = 3;
    int         rx_cd = -1;
    int         tx_cyc[$];
    int         rx_cyc[$];
    int         rsp_cyc[$];
    int         acc_cyc[$];
    int         rsp_first = -1;
    int         stall_idx = -1;
    int         stall_left = 0;
    int         rsp_hold = 0;
    int         rst_idx = -1;
    bit         cmd_pend = 0;
    logic [1:0] cmd_op = 2'd0;
    logic [31:0] cmd_wdata = '0;

    // One clock cycle: drive inputs at the falling edge, observe #1 later, before the next rising edge.
    task automatic tick();
        logic [7:0] e;
        rsp_t       r;
        @(negedge clk);
        cyc++;
        if (rx_cd == 0 && rx_src.size() > 0) begin
            bus.i_rx_valid = 1'b1;
            bus.i_rx_data  = rx_src.pop_front();
            rx_cd = -1;
        end else begin
            bus.i_rx_valid = 1'b0;
            bus.i_rx_data  = 8'h00;
            if (rx_cd > 0) rx_cd--;
        end
        bus.i_tx_ready = 1'b1;
        if (bus.o_tx_valid && stall_left > 0) begin
            bus.i_tx_ready = 1'b0;
            stall_left--;
            vectors++;
            if (tx_exp.size() == 0 || bus.o_tx_data !== tx_exp[0]) begin
                miscompares++;
                $display("FAIL tx_hold cyc %0d: got %02h want %02h", cyc, bus.o_tx_data,
                         (tx_exp.size() > 0) ? tx_exp[0] : 8'hxx);
            end
        end
        bus.i_rsp_ready = 1'b1;
        if (bus.o_rsp_valid && rsp_hold > 0 && rsp_exp.size() > 0) begin
            bus.i_rsp_ready = 1'b0;
            rsp_hold--;
            vectors++;
            if ({bus.o_rsp_data, bus.o_rsp_err} !== rsp_exp[0]) begin
                miscompares++;
                $display("FAIL rsp_hold cyc %0d: got %08h/%0b want %08h/%0b", cyc, bus.o_rsp_data,
                         bus.o_rsp_err, rsp_exp[0].data, rsp_exp[0].err);
            end
        end
        if (rst_idx >= 0 && bus.o_tx_valid && tx_cyc.size() == rst_idx) begin
            rst = 1'b1;
            rst_idx = -1;
        end
        bus.i_cmd_valid = cmd_pend;
        bus.i_cmd_op    = cmd_op;
        bus.i_cmd_wdata = cmd_wdata;
        #1;
        if (bus.i_rx_valid) begin
            vectors++;
            if (bus.o_rx_accept !== 1'b1) begin
                miscompares++;
                $display("FAIL rx_accept cyc %0d: got %0b want 1", cyc, bus.o_rx_accept);
            end
        end
        if (!rst) begin
            if (bus.i_rx_valid) rx_cyc.push_back(cyc);
            if (bus.i_cmd_valid && bus.o_cmd_ready) begin
                acc_cyc.push_back(cyc);
                cmd_pend = 0;
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                vectors++;
                if (tx_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL tx_extra cyc %0d: got %02h want none", cyc, bus.o_tx_data);
                end else begin
                    e = tx_exp.pop_front();
                    if (bus.o_tx_data !== e) begin
                        miscompares++;
                        $display("FAIL tx_byte cyc %0d: got %02h want %02h", cyc, bus.o_tx_data, e);
                    end
                end
                tx_cyc.push_back(cyc);
                if (bus.o_tx_data == 8'h01 && rx_src.size() > 0) rx_cd = rx_lat - 1;
                if (tx_cyc.size() == stall_idx) begin
                    stall_left = 5;
                    stall_idx = -1;
                end
            end
            if (bus.o_rsp_valid && rsp_first < 0) rsp_first = cyc;
            if (bus.o_rsp_valid && bus.i_rsp_ready) begin
                vectors++;
                rsp_cyc.push_back(cyc);
                if (rsp_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_extra cyc %0d: got %08h/%0b want none", cyc, bus.o_rsp_data,
                             bus.o_rsp_err);
                end else begin
                    r = rsp_exp.pop_front();
                    if ({bus.o_rsp_data, bus.o_rsp_err} !== r) begin
                        miscompares++;
                        $display("FAIL rsp cyc %0d: got %08h/%0b want %08h/%0b", cyc, bus.o_rsp_data,
                                 bus.o_rsp_err, r.data, r.err);
                    end
                end
            end
        end
    endtask

    task automatic clear_logs();
        tx_cyc.delete();
        rx_cyc.delete();
        rsp_cyc.delete();
        acc_cyc.delete();
        rsp_first = -1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] wdata);
        int n = 0;
        cmd_op = op;
        cmd_wdata = wdata;
        cmd_pend = 1;
        while (cmd_pend && n < 50) begin
            tick();
            n++;
        end
        if (cmd_pend) begin
            vectors++;
            miscompares++;
            cmd_pend = 0;
            $display("FAIL cmd_accept: not accepted within %0d cycles", n);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rsp_exp.size() > 0 || tx_exp.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (rsp_exp.size() > 0 || tx_exp.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d tx / %0d rsp outstanding after %0d cycles", tx_exp.size(),
                     rsp_exp.size(), budget);
        end
    endtask

    task automatic push_write(input logic [31:0] w);
        for (int i = 7; i >= 0; i--) tx_exp.push_back({w[i*4 +: 4], 4'h0});
        rsp_exp.push_back('{data: 32'h0, err: 1'b0});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.o_tx_valid, bus.o_tx_data, bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err,
             bus.o_busy, bus.o_cmd_ready} !== {1'b0, 8'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_outputs: tx %0b/%02h rsp %0b/%08h/%0b busy %0b ready %0b",
                     bus.o_tx_valid, bus.o_tx_data, bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_err,
                     bus.o_busy, bus.o_cmd_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        clear_logs();
        push_write(32'h1234_ABCD);
        issue(2'd0, 32'h1234_ABCD);
        drain(100);
        vectors++;
        if (tx_cyc.size() != 8 || tx_cyc[0] != acc_cyc[0] + 1 || tx_cyc[7] != tx_cyc[0] + 7) begin
            miscompares++;
            $display("FAIL write_timing: %0d bytes, first at +%0d, span %0d; want 8, +1, 7",
                     tx_cyc.size(), (tx_cyc.size() > 0) ? tx_cyc[0] - acc_cyc[0] : -1,
                     (tx_cyc.size() == 8) ? tx_cyc[7] - tx_cyc[0] : -1);
        end
    endtask

    task automatic test_read();
        clear_logs();
        rx_lat = 3;
        rx_src = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        repeat (4) tx_exp.push_back(8'h01);
        rsp_exp.push_back('{data: 32'hDEAD_BEEF, err: 1'b0});
        issue(2'd1, 32'h0);
        drain(200);
        vectors++;
        if (tx_cyc.size() != 4 || rx_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL read_count: %0d unloads %0d rx; want 4 4", tx_cyc.size(), rx_cyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (tx_cyc[i] != rx_cyc[i-1] + 1 || rx_cyc[i-1] != tx_cyc[i-1] + 3) begin
                    miscompares++;
                    $display("FAIL read_order %0d: unload at %0d rx at %0d", i, tx_cyc[i], rx_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_measure();
        logic [31:0] v;
        clear_logs();
        rx_lat = 2;
        v = $urandom;
        rx_src = '{v[31:24], v[23:16], v[15:8], v[7:0]};
        tx_exp.push_back(8'h02);
        repeat (4) tx_exp.push_back(8'h01);
        rsp_exp.push_back('{data: v, err: 1'b0});
        issue(2'd2, 32'h0);
        drain(200);
        vectors++;
        if (tx_cyc.size() != 5 || tx_cyc[1] != tx_cyc[0] + SETTLE + 1) begin
            miscompares++;
            $display("FAIL measure_settle: gap %0d want %0d",
                     (tx_cyc.size() > 1) ? tx_cyc[1] - tx_cyc[0] : -1, SETTLE + 1);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        tx_exp.push_back(8'h01);
        rsp_exp.push_back('{data: 32'h0, err: 1'b1});
        issue(2'd1, 32'h0);
        drain(RX_TO + 20);
        vectors++;
        if (tx_cyc.size() != 1 || rsp_first != tx_cyc[0] + RX_TO + 1) begin
            miscompares++;
            $display("FAIL timeout_latency: rsp at +%0d want +%0d",
                     (tx_cyc.size() > 0) ? rsp_first - tx_cyc[0] : -1, RX_TO + 1);
        end
        clear_logs();
        push_write(32'h5A5A_0F0F);
        issue(2'd0, 32'h5A5A_0F0F);
        drain(100);
    endtask

    task automatic test_rx_at_timeout();
        clear_logs();
        rx_lat = RX_TO;
        rx_src = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (4) tx_exp.push_back(8'h01);
        rsp_exp.push_back('{data: 32'h1122_3344, err: 1'b0});
        issue(2'd1, 32'h0);
        drain(4 * (RX_TO + 5));
        rx_lat = 3;
    endtask

    task automatic test_op3();
        clear_logs();
        rsp_exp.push_back('{data: 32'h0, err: 1'b1});
        issue(2'd3, 32'hFFFF_FFFF);
        drain(20);
        vectors++;
        if (rsp_first != acc_cyc[0] + 1 || tx_cyc.size() != 0) begin
            miscompares++;
            $display("FAIL op3_latency: rsp at +%0d with %0d tx bytes; want +1 with 0",
                     rsp_first - acc_cyc[0], tx_cyc.size());
        end
    endtask

    task automatic test_stall();
        clear_logs();
        stall_idx = 2;
        rsp_hold = 3;
        push_write(32'h9876_5432);
        issue(2'd0, 32'h9876_5432);
        drain(100);
        vectors++;
        if (tx_cyc.size() != 8 || tx_cyc[2] != tx_cyc[1] + 6) begin
            miscompares++;
            $display("FAIL stall_gap: %0d bytes, gap %0d; want 8, 6", tx_cyc.size(),
                     (tx_cyc.size() > 2) ? tx_cyc[2] - tx_cyc[1] : -1);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        rsp_exp.push_back('{data: 32'h0, err: 1'b1});
        push_write(32'h0000_00F1);
        issue(2'd3, 32'h0);
        issue(2'd0, 32'h0000_00F1);
        drain(100);
        vectors++;
        if (acc_cyc.size() != 2 || rsp_cyc.size() != 2 || acc_cyc[1] != rsp_cyc[0] + 1) begin
            miscompares++;
            $display("FAIL b2b_accept: second accept at %0d, first rsp at %0d",
                     (acc_cyc.size() > 1) ? acc_cyc[1] : -1, (rsp_cyc.size() > 0) ? rsp_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int seen = 0;
        clear_logs();
        rst_idx = 2;
        push_write(32'hCAFE_F00D);
        issue(2'd0, 32'hCAFE_F00D);
        while (!rst && n < 20) begin
            tick();
            n++;
        end
        tick();
        vectors++;
        if (bus.o_tx_valid !== 1'b0 || bus.o_busy !== 1'b0 || !rst) begin
            miscompares++;
            $display("FAIL reset_abort: tx_valid %0b busy %0b rst_hit %0b; want 0 0 1",
                     bus.o_tx_valid, bus.o_busy, rst);
        end
        rst = 1'b0;
        rst_idx = -1;
        tx_exp.delete();
        rsp_exp.delete();
        repeat (10) begin
            tick();
            if (bus.o_tx_valid || bus.o_rsp_valid) seen++;
        end
        vectors++;
        if (seen != 0 || bus.o_cmd_ready !== 1'b1 || tx_cyc.size() != 2) begin
            miscompares++;
            $display("FAIL reset_quiet: %0d active cycles, ready %0b, %0d bytes; want 0 1 2",
                     seen, bus.o_cmd_ready, tx_cyc.size());
        end
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_op    = 2'd0;
        bus.i_cmd_wdata = '0;
        bus.i_tx_ready  = 1'b1;
        bus.i_rx_valid  = 1'b0;
        bus.i_rx_data   = 8'h00;
        bus.i_rsp_ready = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_measure();
        test_timeout();
        test_rx_at_timeout();
        test_op3();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
